// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the IFU/LSU memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RESP      = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin pick between IFU and LSU
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_t last_owner,
    output owner_t grant
);

    // A tie (or no requester at all) goes to whoever was not served last.
    always_comb begin
        grant = other_owner(last_owner);
        if (ifu_valid && !lsu_valid) begin
            grant = OWN_IFU;
        end else if (lsu_valid && !ifu_valid) begin
            grant = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory port between IFU and LSU
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [DW-1:0]   ifu_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [DW-1:0]   lsu_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    output logic            mem_resp_ready,
    input  logic [DW-1:0]   mem_rdata,

    output logic            arb_err
);

    localparam int MW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    // Value the counter holds on the final wait cycle before giving up.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state;
    owner_t        owner;
    owner_t        last_owner;
    owner_t        grant;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic [DW-1:0] rdata_q;
    logic [CW-1:0] cnt;

    logic idle;
    logic accept;
    logic owner_resp_ready;

    arb_rr2 u_rr (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_owner (last_owner),
        .grant      (grant)
    );

    // Ready is gated by rst so the request side goes quiet the instant reset rises.
    assign idle          = (state == S_IDLE) && !rst;
    assign ifu_req_ready = idle && (grant == OWN_IFU) && ifu_req_valid;
    assign lsu_req_ready = idle && (grant == OWN_LSU) && lsu_req_valid;
    assign accept        = ifu_req_ready || lsu_req_ready;

    assign mem_req_valid  = (state == S_REQ);
    assign mem_resp_ready = (state == S_WAIT_RESP);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    assign ifu_resp_valid   = (state == S_RESP) && (owner == OWN_IFU);
    assign lsu_resp_valid   = (state == S_RESP) && (owner == OWN_LSU);
    assign ifu_rdata        = rdata_q;
    assign lsu_rdata        = rdata_q;
    assign owner_resp_ready = (owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IFU;
            last_owner <= OWN_LSU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
            arb_err    <= 1'b0;
        end else begin
            arb_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner <= grant;
                        state <= S_REQ;
                        if (grant == OWN_IFU) begin
                            addr_q  <= ifu_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end else begin
                            addr_q  <= lsu_addr;
                            wen_q   <= lsu_wen;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    // A response arriving on the final wait cycle still beats the timeout.
                    if (mem_resp_valid) begin
                        rdata_q <= mem_rdata;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            rdata_q <= '0;
                            arb_err <= 1'b1;
                            state   <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (owner_resp_ready) begin
                        last_owner <= owner;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
    logic [31:0] ifu_addr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid, lsu_resp_ready = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic        lsu_wen = 1'b0;
    logic [3:0]  lsu_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wmask;
    logic        arb_err;

    int n_checks = 0;
    int n_pass   = 0;
    int m_last   = 1;

    int          r_own, r_lat, r_errs, r_errk, r_wcnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wmask;
    logic        r_wen, r_stable, r_quiet, r_done;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // Reference rule: a lone requester wins, a tie goes to whoever was not served last.
    function automatic int exp_owner(input bit iv, input bit lv, input int last);
        if (iv && lv) return (last == 0) ? 1 : 0;
        return iv ? 0 : 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_last = 1;
    endtask

    // One transaction: present requests, act as memory and requester, record what was observed.
    task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                          input bit lw, input logic [31:0] ld, input logic [3:0] lm,
                          input logic [31:0] mval, input int req_dly, input int resp_dly, input int rr_dly);
        int ph, hold, k;
        logic orv, nrv;
        logic [31:0] ord;
        r_own = -1; r_lat = -1; r_errs = 0; r_errk = -1; r_wcnt = 0;
        r_stable = 1'b1; r_quiet = 1'b1; r_done = 1'b0; r_rdata = 'x;
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = ld; lsu_wmask = lm;
        for (int c = 0; c < 20 && r_own < 0; c++) begin
            @(negedge clk);
            if (ifu_req_valid && ifu_req_ready) r_own = 0;
            else if (lsu_req_valid && lsu_req_ready) r_own = 1;
            @(posedge clk);
            #1;
        end
        if (r_own < 0) begin
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            return;
        end
        if (r_own == 0) ifu_req_valid = 1'b0; else lsu_req_valid = 1'b0;
        ph = 0; hold = 0;
        for (k = 1; k < 700 && ph != 3; k++) begin
            mem_req_ready  = (ph == 0) && (hold >= req_dly);
            mem_resp_valid = (ph == 1) && (resp_dly >= 0) && (hold >= resp_dly);
            mem_rdata      = mem_resp_valid ? mval : $urandom;
            ifu_resp_ready = (ph == 2) && (r_own == 0) && (hold >= rr_dly);
            lsu_resp_ready = (ph == 2) && (r_own == 1) && (hold >= rr_dly);
            @(negedge clk);
            orv = (r_own == 0) ? ifu_resp_valid : lsu_resp_valid;
            nrv = (r_own == 0) ? lsu_resp_valid : ifu_resp_valid;
            ord = (r_own == 0) ? ifu_rdata : lsu_rdata;
            if (arb_err) begin r_errs++; r_errk = k; end
            if (ifu_req_ready || lsu_req_ready || nrv) r_quiet = 1'b0;
            if (ph == 0 && mem_req_valid) begin
                if (hold == 0) begin
                    r_addr = mem_addr; r_wen = mem_wen; r_wdata = mem_wdata; r_wmask = mem_wmask;
                end else if ({r_addr, r_wen, r_wdata, r_wmask} !== {mem_addr, mem_wen, mem_wdata, mem_wmask}) begin
                    r_stable = 1'b0;
                end
                if (mem_req_ready) begin ph = 1; hold = 0; end else hold++;
            end else if (ph == 1) begin
                if (mem_resp_ready) r_wcnt++;
                if (mem_resp_valid && mem_resp_ready) begin ph = 2; hold = 0; end
                else if (orv) begin ph = 2; hold = 0; end
                else if (mem_resp_ready) hold++;
            end
            if (ph == 2 && orv) begin
                if (r_lat < 0) begin r_lat = k; r_rdata = ord; end
                else if (ord !== r_rdata) r_stable = 1'b0;
                if ((r_own == 0) ? ifu_resp_ready : lsu_resp_ready) ph = 3; else hold++;
            end
            @(posedge clk);
            #1;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        r_done = (ph == 3);
    endtask

    task automatic test_reset();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #2;
        n_checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, arb_err} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, arb_err}); else n_pass++;
        n_checks++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'd0)
            $display("FAIL reset_mem_fields: got %h/%b/%h/%h want zeros", mem_addr, mem_wen, mem_wdata, mem_wmask); else n_pass++;
        n_checks++; if ({ifu_rdata, lsu_rdata} !== 64'd0)
            $display("FAIL reset_rdata: got %h/%h want 0", ifu_rdata, lsu_rdata); else n_pass++;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_last = 1;
    endtask

    task automatic test_single_fetch();
        do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0413, 0, 0, 0);
        n_checks++; if (r_done !== 1'b1 || r_own !== 0) $display("FAIL fetch_done_owner: got done=%0b owner=%0d want 1/0", r_done, r_own); else n_pass++;
        n_checks++; if (r_lat !== 3) $display("FAIL fetch_latency: got %0d want 3", r_lat); else n_pass++;
        n_checks++; if (r_rdata !== 32'h0000_0413) $display("FAIL fetch_rdata: got %h want 00000413", r_rdata); else n_pass++;
        n_checks++; if ({r_addr, r_wen, r_wmask} !== {32'h8000_0000, 1'b0, 4'h0}) $display("FAIL fetch_mem_fields: got %h/%b/%h want 80000000/0/0", r_addr, r_wen, r_wmask); else n_pass++;
        n_checks++; if (r_quiet !== 1'b1) $display("FAIL fetch_lsu_quiet: got %b want 1", r_quiet); else n_pass++;
        m_last = 0;
    endtask

    task automatic test_tie();
        do_reset();
        do_txn(1, 1, 32'h8000_0004, 32'h8000_1000, 1, 32'hCAFE_BABE, 4'hF, 32'h1111_2222, 0, 0, 0);
        n_checks++; if (r_own !== 0) $display("FAIL tie_first_owner: got %0d want 0", r_own); else n_pass++;
        n_checks++; if ({r_addr, r_wen, r_wdata, r_wmask} !== {32'h8000_0004, 1'b0, 32'h0, 4'h0})
            $display("FAIL tie_ifu_fields: got %h/%b/%h/%h want 80000004/0/0/0", r_addr, r_wen, r_wdata, r_wmask); else n_pass++;
        n_checks++; if (r_quiet !== 1'b1) $display("FAIL tie_no_second_accept: got %b want 1", r_quiet); else n_pass++;
        do_txn(0, 1, 32'h0, 32'h8000_1000, 1, 32'hCAFE_BABE, 4'hF, 32'h3333_4444, 0, 0, 0);
        n_checks++; if (r_own !== 1) $display("FAIL tie_second_owner: got %0d want 1", r_own); else n_pass++;
        n_checks++; if ({r_addr, r_wen, r_wdata, r_wmask} !== {32'h8000_1000, 1'b1, 32'hCAFE_BABE, 4'hF})
            $display("FAIL tie_lsu_fields: got %h/%b/%h/%h want 80001000/1/cafebabe/f", r_addr, r_wen, r_wdata, r_wmask); else n_pass++;
        n_checks++; if (r_rdata !== 32'h3333_4444) $display("FAIL tie_lsu_rdata: got %h want 33334444", r_rdata); else n_pass++;
        m_last = 1;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_txn(1, 1, $urandom & ~32'h3, $urandom & ~32'h3, 1'($urandom), $urandom, 4'($urandom), $urandom, 0, 0, 0);
            n_checks++; if (r_own !== (i % 2)) $display("FAIL alternate_owner[%0d]: got %0d want %0d", i, r_own, i % 2); else n_pass++;
            m_last = i % 2;
        end
    endtask

    task automatic test_stall();
        logic [31:0] v;
        do_reset();
        do_txn(1, 0, 32'h8000_0100, 32'h0, 0, 32'h0, 4'h0, 32'h5, 0, 0, 0);
        m_last = 0;
        v = $urandom;
        do_txn(1, 1, 32'h8000_0200, 32'h8000_2000, 1, 32'h0BAD_F00D, 4'h3, v, 5, 1, 4);
        n_checks++; if (r_own !== exp_owner(1, 1, m_last)) $display("FAIL stall_owner: got %0d want %0d", r_own, exp_owner(1, 1, m_last)); else n_pass++;
        n_checks++; if (r_stable !== 1'b1) $display("FAIL stall_stable: got %b want 1", r_stable); else n_pass++;
        n_checks++; if (r_quiet !== 1'b1) $display("FAIL stall_no_accept: got %b want 1", r_quiet); else n_pass++;
        n_checks++; if (r_lat !== 9) $display("FAIL stall_latency: got %0d want 9", r_lat); else n_pass++;
        n_checks++; if (r_rdata !== v) $display("FAIL stall_rdata: got %h want %h", r_rdata, v); else n_pass++;
        m_last = 1;
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        do_txn(1, 0, 32'h8000_0300, 32'h0, 0, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, -1, 0);
        n_checks++; if (r_done !== 1'b1 || r_own !== 0) $display("FAIL timeout_done: got done=%0b owner=%0d want 1/0", r_done, r_own); else n_pass++;
        n_checks++; if (r_wcnt !== TO) $display("FAIL timeout_wait_cycles: got %0d want %0d", r_wcnt, TO); else n_pass++;
        n_checks++; if (r_errs !== 1 || r_errk !== r_lat) $display("FAIL timeout_err_pulse: got count=%0d at=%0d want 1 at %0d", r_errs, r_errk, r_lat); else n_pass++;
        n_checks++; if (r_lat !== 2 + TO) $display("FAIL timeout_latency: got %0d want %0d", r_lat, 2 + TO); else n_pass++;
        n_checks++; if (r_rdata !== 32'h0) $display("FAIL timeout_rdata: got %h want 00000000", r_rdata); else n_pass++;
        m_last = 0;
        v = $urandom | 32'h1;
        do_txn(0, 1, 32'h0, 32'h8000_0400, 0, 32'h0, 4'h0, v, 0, TO - 1, 0);
        n_checks++; if (r_errs !== 0) $display("FAIL last_cycle_resp_err: got %0d pulses want 0", r_errs); else n_pass++;
        n_checks++; if (r_rdata !== v || r_lat !== 2 + TO) $display("FAIL last_cycle_resp_data: got %h lat %0d want %h lat %0d", r_rdata, r_lat, v, 2 + TO); else n_pass++;
        m_last = 1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int c;
        seen = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0500;
        mem_req_ready = 1'b1;
        for (c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = mem_resp_ready;
            @(posedge clk);
            #1;
            ifu_req_valid = 1'b0;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL rstmid_reach_wait: got %b want 1", seen); else n_pass++;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, arb_err} !== 7'b0)
            $display("FAIL rstmid_outputs: got %b want 0000000", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, arb_err}); else n_pass++;
        n_checks++; if ({mem_addr, ifu_rdata} !== 64'd0) $display("FAIL rstmid_fields: got %h/%h want 0", mem_addr, ifu_rdata); else n_pass++;
        mem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid || mem_resp_ready || arb_err) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_late_resp: got %b want 0", seen); else n_pass++;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        m_last = 1;
    endtask

    task automatic test_random();
        bit iv, lv, lw;
        int eo, rq, rs;
        logic [31:0] ia, la, ld, v;
        logic [3:0] lm;
        for (int i = 0; i < 24; i++) begin
            iv = 1'($urandom); lv = 1'($urandom);
            if (!iv && !lv) iv = 1'b1;
            ia = $urandom & ~32'h3; la = $urandom; lw = 1'($urandom); ld = $urandom; lm = 4'($urandom); v = $urandom;
            rq = $urandom_range(3, 0); rs = $urandom_range(4, 0);
            eo = exp_owner(iv, lv, m_last);
            do_txn(iv, lv, ia, la, lw, ld, lm, v, rq, rs, $urandom_range(3, 0));
            n_checks++; if (r_done !== 1'b1 || r_own !== eo) $display("FAIL rand_owner[%0d]: got done=%0b owner=%0d want 1/%0d", i, r_done, r_own, eo); else n_pass++;
            n_checks++; if ({r_addr, r_wen, r_wdata, r_wmask} !== ((eo == 0) ? {ia, 1'b0, 32'h0, 4'h0} : {la, lw, ld, lm}))
                $display("FAIL rand_fields[%0d]: got %h/%b/%h/%h", i, r_addr, r_wen, r_wdata, r_wmask); else n_pass++;
            n_checks++; if (r_rdata !== v) $display("FAIL rand_rdata[%0d]: got %h want %h", i, r_rdata, v); else n_pass++;
            n_checks++; if (r_lat !== 3 + rq + rs) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, r_lat, 3 + rq + rs); else n_pass++;
            n_checks++; if (r_errs !== 0 || r_stable !== 1'b1 || r_quiet !== 1'b1)
                $display("FAIL rand_clean[%0d]: got err=%0d stable=%b quiet=%b want 0/1/1", i, r_errs, r_stable, r_quiet); else n_pass++;
            m_last = eo;
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_alternate();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; write mask width DW/8.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for memory response.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ifu_req_valid/ifu_req_ready  in/out  1/1  IFU fetch request handshake; ifu_addr  input  AW.
REQ-007 ifu_resp_valid/ifu_resp_ready  out/in  1/1  IFU response handshake; ifu_rdata  output  DW.
REQ-008 lsu_req_valid/lsu_req_ready  in/out  1/1  LSU request handshake; lsu_addr AW, lsu_wen 1, lsu_wdata DW, lsu_wmask DW/8, all inputs.
REQ-009 lsu_resp_valid/lsu_resp_ready  out/in  1/1  LSU response handshake; lsu_rdata  output  DW.
REQ-010 mem_req_valid/mem_req_ready  out/in  1/1  shared memory port request; mem_addr AW, mem_wen 1, mem_wdata DW, mem_wmask DW/8, all outputs.
REQ-011 mem_resp_valid/mem_resp_ready  in/out  1/1  memory response; mem_rdata  input  DW.
REQ-012 arb_err  output  1  one-cycle pulse on response timeout.

Function
REQ-013 FSM states: S_IDLE, S_REQ, S_WAIT_RESP, S_RESP; one transaction outstanding at a time.
REQ-014 S_IDLE: req_ready asserted only for the selected requester, only when its req_valid is high; the other req_ready is low; all other states hold both req_ready low.
REQ-015 Selection: single valid requester wins; both valid -> requester not granted last (round-robin bit last_owner).
REQ-016 On accept (valid&ready in S_IDLE): latch owner, addr, wen, wdata, wmask; IFU transfers latch wen=0, wmask=0, wdata=0; next state S_REQ.
REQ-017 S_REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready -> S_WAIT_RESP, timeout counter cleared.
REQ-018 S_WAIT_RESP: mem_resp_ready=1; on mem_resp_valid capture mem_rdata -> S_RESP; else counter increments.
REQ-019 Counter reaching TIMEOUT in S_WAIT_RESP without mem_resp_valid: capture rdata = 0, pulse arb_err for one cycle, -> S_RESP.
REQ-020 mem_resp_valid in the same cycle the counter reaches TIMEOUT: response wins, no arb_err.
REQ-021 S_RESP: owner's resp_valid=1 with captured data held stable; non-owner resp_valid=0; on owner resp_ready -> S_IDLE, last_owner <= owner.
REQ-022 mem_req_valid low outside S_REQ; mem_resp_ready low outside S_WAIT_RESP; mem_resp_valid outside S_WAIT_RESP ignored.
REQ-023 Minimum latency accept-to-resp_valid: 3 cycles (zero-wait memory); back-to-back accept possible the cycle after resp handshake.
REQ-024 rdata outputs drive the captured register regardless of state; value defined only while resp_valid.

Reset
REQ-025 rst asserted: state S_IDLE, last_owner = LSU (IFU wins first tie), counter 0, latched fields and rdata 0, all valid/ready outputs and arb_err 0, immediately (asynchronously).
REQ-026 Reset mid-transaction discards it; no response delivered to either requester afterwards.

Structure
REQ-027 Package mem_arb_pkg holds arb_state_t (four states), owner_t {OWN_IFU, OWN_LSU}, and default TIMEOUT constant.
REQ-028 One sub-module arb_rr2: combinational two-way round-robin pick from (ifu_valid, lsu_valid, last_owner) -> grant owner.

Verification
REQ-029 Single IFU fetch addr 0x80000000, mem zero-wait returns 0x00000413 -> ifu_resp_valid 3 cycles after accept with ifu_rdata 0x00000413, lsu_resp_valid stays 0.
REQ-030 Both valid after reset, IFU 0x80000004, LSU write 0x80001000 data 0xCAFEBABE mask 0xF -> IFU served first, then LSU; mem_wen=1, mem_wmask=0xF on the second request.
REQ-031 Both continuously valid for 6 transactions -> grants alternate IFU, LSU, IFU, LSU, IFU, LSU.
REQ-032 mem_req_ready held low 5 cycles, LSU resp_ready held low 4 cycles -> mem fields and lsu_rdata stable throughout, no new accept.
REQ-033 mem_resp_valid never asserted -> arb_err single pulse after TIMEOUT=255 wait cycles, owner resp_valid with rdata 0x00000000.
REQ-034 rst asserted during S_WAIT_RESP, then late mem_resp_valid -> all outputs 0 immediately, no resp_valid to either requester.
